// File: rtl/column_frame_buffer.sv
// column_frame_buffer: ping-pong column store of {side, wall_height}, swapped on vsync,
// rendered as ceiling/wall/floor colour through a 2-stage pixel pipeline.
module column_frame_buffer #(
  parameter int          NUM_COLS   = 640,
  parameter int          SCREEN_H   = 480,
  parameter logic [11:0] CEIL_RGB   = 12'h446,
  parameter logic [11:0] FLOOR_RGB  = 12'h222,
  parameter logic [11:0] WALL_RGB_X = 12'hF00,
  parameter logic [11:0] WALL_RGB_Y = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        height_valid,
  input  logic [9:0]  wall_height,
  input  logic        side,
  input  logic        vsync_pulse,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pixel_active,
  output logic        write_new_frame,
  output logic        frame_written,
  output logic        overflow_err,
  output logic [11:0] pixel_rgb
);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  localparam logic [9:0] SH = 10'(SCREEN_H);
  localparam logic [9:0] LAST_COL = 10'(NUM_COLS - 1);
  state_t      state_q, state_d;
  logic [9:0]  wr_col_q, wr_col_d;
  logic        disp_bank_q, disp_bank_d;
  logic [1:0]  bank_valid_q, bank_valid_d;
  logic        frame_written_q, overflow_q, wr_en;
  logic [10:0] wr_data;
  logic [10:0] mem [2][NUM_COLS];
  logic [9:0]  y1_q;
  logic        act1_q, v1_q;
  logic [10:0] rd1_q;
  logic [9:0]  h, top;
  logic [11:0] rgb_d, rgb_q;
  assign wr_data = {side, (wall_height > SH) ? SH : wall_height};
  always_comb begin
    state_d      = state_q;
    wr_col_d     = wr_col_q;
    disp_bank_d  = disp_bank_q;
    bank_valid_d = bank_valid_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: if (frame_start) begin
        state_d  = FILL;
        wr_col_d = '0;
      end
      FILL: if (frame_start) begin
        wr_col_d = '0;
      end else if (height_valid) begin
        wr_en    = 1'b1;
        wr_col_d = wr_col_q + 10'd1;
        if (wr_col_q == LAST_COL) begin
          state_d = FULL;
          bank_valid_d[~disp_bank_q] = 1'b1;
        end
      end
      FULL: if (vsync_pulse) begin
        disp_bank_d = ~disp_bank_q;
        wr_col_d    = '0;
        state_d     = frame_start ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wr_col_q        <= '0;
      disp_bank_q     <= 1'b0;
      bank_valid_q    <= 2'b00;
      frame_written_q <= 1'b0;
      overflow_q      <= 1'b0;
      y1_q            <= '0;
      act1_q          <= 1'b0;
      v1_q            <= 1'b0;
      rd1_q           <= '0;
      rgb_q           <= '0;
    end else begin
      state_q         <= state_d;
      wr_col_q        <= wr_col_d;
      disp_bank_q     <= disp_bank_d;
      bank_valid_q    <= bank_valid_d;
      frame_written_q <= wr_en && (wr_col_q == LAST_COL);
      overflow_q      <= overflow_q | (height_valid && state_q != FILL);
      y1_q            <= pixel_y;
      act1_q          <= pixel_active;
      v1_q            <= bank_valid_q[disp_bank_q];
      rd1_q           <= mem[disp_bank_q][pixel_x];
      rgb_q           <= rgb_d;
    end
  end
  // Bank RAM has no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (wr_en) mem[~disp_bank_q][wr_col_q] <= wr_data;
  end
  assign h     = v1_q ? rd1_q[9:0] : 10'd0;
  assign top   = (SH - h) >> 1;
  assign rgb_d = !act1_q        ? 12'h000 :
                 y1_q < top     ? CEIL_RGB :
                 y1_q < top + h ? (rd1_q[10] ? WALL_RGB_Y : WALL_RGB_X) :
                                  FLOOR_RGB;
  assign write_new_frame = state_q == FILL;
  assign frame_written   = frame_written_q;
  assign overflow_err    = overflow_q;
  assign pixel_rgb       = rgb_q;
endmodule

// File: tb/tb_column_frame_buffer.sv
// tb_column_frame_buffer: directed scenarios for column_frame_buffer with hand-computed colours.
module tb_column_frame_buffer;
  logic        clk = 0, rst_n = 0, frame_start = 0, height_valid = 0, side = 0;
  logic        vsync_pulse = 0, pixel_active = 0;
  logic [9:0]  wall_height = 0, pixel_x = 0, pixel_y = 0;
  logic        write_new_frame, frame_written, overflow_err;
  logic [11:0] pixel_rgb;
  int          n_cmp = 0, n_bad = 0, fw_cnt = 0;

  column_frame_buffer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .height_valid(height_valid),
    .wall_height(wall_height), .side(side), .vsync_pulse(vsync_pulse),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_active(pixel_active),
    .write_new_frame(write_new_frame), .frame_written(frame_written),
    .overflow_err(overflow_err), .pixel_rgb(pixel_rgb)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    if (frame_written) fw_cnt++;
  endtask

  task automatic scan(input int x, input int y, output logic [11:0] rgb);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    pixel_active = 1;
    tick;
    pixel_active = 0;
    tick;
    rgb = pixel_rgb;
  endtask

  task automatic fill(input bit fs, input int n, input logic [9:0] h, input logic s,
                      input int sc = -1, input logic [9:0] sh = 0, input logic ss = 0);
    if (fs) begin
      frame_start = 1;
      tick;
      frame_start = 0;
    end
    for (int i = 0; i < n; i++) begin
      height_valid = 1;
      wall_height  = (i == sc) ? sh : h;
      side         = (i == sc) ? ss : s;
      tick;
    end
    height_valid = 0;
  endtask

  task automatic vsync;
    vsync_pulse = 1;
    tick;
    vsync_pulse = 0;
  endtask

  task automatic test_reset;
    logic [11:0] r;
    int xs[2] = '{5, 5};
    int ys[2] = '{100, 300};
    logic [11:0] ex[2] = '{12'h446, 12'h222};
    rst_n = 0;
    tick;
    tick;
    n_cmp += 4;
    if (write_new_frame !== 1'b0) begin n_bad++; $display("FAIL rst_wnf: got %b want 0", write_new_frame); end
    if (frame_written !== 1'b0) begin n_bad++; $display("FAIL rst_fw: got %b want 0", frame_written); end
    if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow_err); end
    if (pixel_rgb !== 12'h000) begin n_bad++; $display("FAIL rst_rgb: got %h want 000", pixel_rgb); end
    rst_n = 1;
    tick;
    for (int i = 0; i < 2; i++) begin
      scan(xs[i], ys[i], r);
      n_cmp++;
      if (r !== ex[i]) begin n_bad++; $display("FAIL rst_scan y=%0d: got %h want %h", ys[i], r, ex[i]); end
    end
    n_cmp += 2;
    if (write_new_frame !== 1'b0) begin n_bad++; $display("FAIL rst_wnf2: got %b want 0", write_new_frame); end
    if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL rst_ovf2: got %b want 0", overflow_err); end
  endtask

  task automatic test_fill;
    logic [11:0] r;
    int fw0 = fw_cnt;
    int ys[4] = '{189, 190, 289, 290};
    logic [11:0] ex[4] = '{12'h446, 12'hF00, 12'hF00, 12'h222};
    frame_start = 1;
    tick;
    frame_start = 0;
    n_cmp++;
    if (write_new_frame !== 1'b1) begin n_bad++; $display("FAIL fill_wnf: got %b want 1", write_new_frame); end
    fill(0, 640, 100, 0);
    tick;
    n_cmp += 2;
    if (fw_cnt - fw0 !== 1) begin n_bad++; $display("FAIL fill_fw_count: got %0d want 1", fw_cnt - fw0); end
    if (write_new_frame !== 1'b0) begin n_bad++; $display("FAIL fill_wnf_full: got %b want 0", write_new_frame); end
    scan(5, 100, r);
    n_cmp++;
    if (r !== 12'h446) begin n_bad++; $display("FAIL fill_preswap: got %h want 446", r); end
    vsync;
    for (int i = 0; i < 4; i++) begin
      scan(5, ys[i], r);
      n_cmp++;
      if (r !== ex[i]) begin n_bad++; $display("FAIL fill_scan y=%0d: got %h want %h", ys[i], r, ex[i]); end
    end
  endtask

  task automatic test_clamp;
    logic [11:0] r;
    int xs[4] = '{7, 7, 8, 8};
    int ys[4] = '{0, 479, 214, 215};
    logic [11:0] ex[4] = '{12'h800, 12'h800, 12'h446, 12'hF00};
    fill(1, 640, 50, 0, 7, 600, 1);
    vsync;
    for (int i = 0; i < 4; i++) begin
      scan(xs[i], ys[i], r);
      n_cmp++;
      if (r !== ex[i]) begin n_bad++; $display("FAIL clamp x=%0d y=%0d: got %h want %h", xs[i], ys[i], r, ex[i]); end
    end
  endtask

  task automatic test_restart;
    logic [11:0] r;
    int fw0 = fw_cnt;
    int ys[5] = '{100, 229, 230, 249, 250};
    logic [11:0] ex[5] = '{12'h446, 12'h446, 12'hF00, 12'hF00, 12'h222};
    fill(1, 300, 300, 0);
    fill(1, 640, 20, 0);
    tick;
    n_cmp++;
    if (fw_cnt - fw0 !== 1) begin n_bad++; $display("FAIL restart_fw_count: got %0d want 1", fw_cnt - fw0); end
    vsync;
    for (int i = 0; i < 5; i++) begin
      scan(0, ys[i], r);
      n_cmp++;
      if (r !== ex[i]) begin n_bad++; $display("FAIL restart y=%0d: got %h want %h", ys[i], r, ex[i]); end
    end
  endtask

  task automatic test_vsync_fill_overflow;
    logic [11:0] r;
    fill(1, 10, 100, 0);
    vsync;
    n_cmp++;
    if (write_new_frame !== 1'b1) begin n_bad++; $display("FAIL vfill_wnf: got %b want 1", write_new_frame); end
    scan(0, 230, r);
    n_cmp++;
    if (r !== 12'hF00) begin n_bad++; $display("FAIL vfill_disp: got %h want F00", r); end
    fill(0, 630, 100, 0);
    tick;
    n_cmp++;
    if (write_new_frame !== 1'b0) begin n_bad++; $display("FAIL vfill_full: got %b want 0", write_new_frame); end
    height_valid = 1;
    wall_height  = 5;
    tick;
    height_valid = 0;
    tick;
    n_cmp++;
    if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
    scan(0, 230, r);
    n_cmp++;
    if (r !== 12'hF00) begin n_bad++; $display("FAIL ovf_noswap: got %h want F00", r); end
    vsync;
    scan(639, 190, r);
    n_cmp++;
    if (r !== 12'hF00) begin n_bad++; $display("FAIL ovf_col639_wall: got %h want F00", r); end
    scan(639, 189, r);
    n_cmp++;
    if (r !== 12'h446) begin n_bad++; $display("FAIL ovf_col639_ceil: got %h want 446", r); end
    scan(0, 290, r);
    n_cmp += 2;
    if (r !== 12'h222) begin n_bad++; $display("FAIL ovf_col0_floor: got %h want 222", r); end
    if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] r;
    int fw0;
    fill(1, 640, 200, 1);
    frame_start = 1;
    vsync_pulse = 1;
    tick;
    frame_start = 0;
    vsync_pulse = 0;
    n_cmp++;
    if (write_new_frame !== 1'b1) begin n_bad++; $display("FAIL b2b_wnf: got %b want 1", write_new_frame); end
    scan(5, 140, r);
    n_cmp++;
    if (r !== 12'h800) begin n_bad++; $display("FAIL b2b_wall: got %h want 800", r); end
    scan(5, 139, r);
    n_cmp++;
    if (r !== 12'h446) begin n_bad++; $display("FAIL b2b_ceil: got %h want 446", r); end
    fw0 = fw_cnt;
    fill(0, 639, 50, 0);
    tick;
    n_cmp++;
    if (fw_cnt - fw0 !== 0) begin n_bad++; $display("FAIL b2b_early_fw: got %0d want 0", fw_cnt - fw0); end
    fill(0, 1, 50, 0);
    tick;
    n_cmp++;
    if (fw_cnt - fw0 !== 1) begin n_bad++; $display("FAIL b2b_fw: got %0d want 1", fw_cnt - fw0); end
    vsync;
    scan(8, 215, r);
    n_cmp++;
    if (r !== 12'hF00) begin n_bad++; $display("FAIL b2b_new_wall: got %h want F00", r); end
    scan(8, 214, r);
    n_cmp++;
    if (r !== 12'h446) begin n_bad++; $display("FAIL b2b_new_ceil: got %h want 446", r); end
  endtask

  task automatic test_reset_mid_fill;
    logic [11:0] r;
    fill(1, 100, 100, 0);
    rst_n = 0;
    tick;
    n_cmp += 2;
    if (write_new_frame !== 1'b0) begin n_bad++; $display("FAIL midrst_wnf: got %b want 0", write_new_frame); end
    if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %b want 0", overflow_err); end
    rst_n = 1;
    tick;
    scan(5, 239, r);
    n_cmp++;
    if (r !== 12'h446) begin n_bad++; $display("FAIL midrst_ceil: got %h want 446", r); end
    scan(5, 240, r);
    n_cmp++;
    if (r !== 12'h222) begin n_bad++; $display("FAIL midrst_floor: got %h want 222", r); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_clamp;
    test_restart;
    test_vsync_fill_overflow;
    test_back_to_back;
    test_reset_mid_fill;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/column_frame_buffer.md
Name: column_frame_buffer

Overview:
- Downstream of the wall-height stage. Captures one {wall_height, side} entry per screen column into a ping-pong column buffer.
- On vsync, swaps the completed buffer to the display side.
- On the display side, converts the VGA scan position into a ceiling, wall or floor pixel colour through a 2-cycle pipeline.
- Drives write_new_frame back to the height stage so heights are only produced while a write bank is open.

Parameters:
- NUM_COLS, 640: columns per frame, which is also the depth of each bank.
- SCREEN_H, 480: visible rows; also the maximum wall height.
- CEIL_RGB, 12'h446: ceiling colour.
- FLOOR_RGB, 12'h222: floor colour.
- WALL_RGB_X, 12'hF00: wall colour when side=0.
- WALL_RGB_Y, 12'h800: wall colour when side=1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse; opens a new write frame.
- height_valid  input  1  one-cycle strobe; wall_height and side are valid this cycle.
- wall_height  input  10  column wall height in pixels.
- side  input  1  wall face hit for this column (0 = x-side, 1 = y-side).
- vsync_pulse  input  1  one-cycle pulse at end of the visible frame; swap point.
- pixel_x  input  10  VGA column, 0..NUM_COLS-1.
- pixel_y  input  10  VGA row, 0..SCREEN_H-1.
- pixel_active  input  1  high inside the visible area.
- write_new_frame  output  1  high while the write bank accepts columns.
- frame_written  output  1  one-cycle pulse when the last column is stored.
- overflow_err  output  1  sticky flag; a strobe arrived while the block was not filling.
- pixel_rgb  output  12  RGB444 pixel colour.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wr_col=0, disp_bank=0, bank_valid=2'b00, write_new_frame=0, frame_written=0, overflow_err=0, pixel_rgb=0, pipeline registers cleared. Bank RAM contents are not reset.
- Banks: two arrays of NUM_COLS x 11 bits ({side, height}). The write bank is always ~disp_bank.
- Height clamp on write: a stored height of min(wall_height, SCREEN_H).
- FSM:
  - IDLE: write_new_frame=0. On frame_start: go to FILL, wr_col=0.
  - FILL: write_new_frame=1. On height_valid: write the entry at wr_col and increment wr_col. If the write is at wr_col=NUM_COLS-1: go to FULL, set bank_valid[write bank]=1, pulse frame_written for one cycle (registered, asserted the cycle after that write).
    - frame_start in FILL: wr_col=0, stay in FILL. The partial frame is abandoned and overwritten.
    - vsync_pulse in FILL: ignored; no swap, display unchanged.
  - FULL: write_new_frame=0. On vsync_pulse: toggle disp_bank, go to IDLE.
    - If frame_start and vsync_pulse occur in the same cycle in FULL: swap, then go directly to FILL with wr_col=0.
- write_new_frame is registered and reflects the current state (high exactly in FILL).
- overflow_err: set when height_valid=1 while the state is not FILL. That data is discarded. The flag clears only on reset.
- Pixel pipeline (latency 2):
  - Stage 1: register pixel_y and pixel_active; read the display bank at pixel_x.
  - Stage 2: h = bank_valid[disp_bank] ? stored height : 0. top = (SCREEN_H - h) >> 1.
    - Inactive → 0.
    - pixel_y < top → CEIL_RGB.
    - pixel_y < top + h → WALL_RGB_X if side=0, else WALL_RGB_Y.
    - Otherwise → FLOOR_RGB.
  - pixel_rgb corresponds to the pixel_x/pixel_y/pixel_active sampled 2 rising edges earlier.
- Swap timing: stage 1 uses the disp_bank value in effect at its own sampling edge. Pixels in flight at a swap may mix banks; this is acceptable because the swap occurs in blanking.
- pixel_x >= NUM_COLS while active: the read is undefined; the upstream VGA timing never drives this.
- Width rules: top and top+h are computed in 10 bits with no overflow, since h <= SCREEN_H.
- Reset mid-FILL: all state returns to reset values and bank_valid clears, so the display shows h=0 (ceiling rows 0..239, floor rows 240..479).

Test Plan:
- Reset then scan (x=5, y=100, active) → pixel_rgb=12'h446 two cycles later; (x=5, y=300) → 12'h222; write_new_frame=0, overflow_err=0.
- frame_start, 640 strobes with height=100, side=0, then vsync_pulse → write_new_frame high during fill; frame_written pulses once after the 640th strobe; after swap, y=189 → 12'h446, y=190 → 12'hF00, y=289 → 12'hF00, y=290 → 12'h222.
- Fill with column 7 at height=600, side=1 and all others at 50 → column 7 clamped to 480: y=0 and y=479 → 12'h800; column 8 at y=214 → 12'h446 and y=215 → 12'hF00.
- frame_start, 300 strobes, then frame_start again and 640 strobes of height 20 → column 0 shows height 20, not the first-pass value; frame_written pulses exactly once.
- vsync_pulse during FILL → display unchanged. One height_valid in FULL → overflow_err=1 and stays 1; the stored bank is unaffected.
- Simultaneous frame_start and vsync_pulse in FULL → disp_bank toggles, state FILL, write_new_frame=1 next cycle, wr_col=0.
